// File: rtl/encoder_pkg.sv
// Shared encoder definitions.
// Provides the single-turn width shared with the SPI reader, the tracker
// state encoding and the fault codes reported to motion control.
package encoder_pkg;

    localparam int unsigned ENC_POS_W = 19;

    typedef enum logic [1:0] {
        INIT  = 2'd0,
        TRACK = 2'd1,
        FAULT = 2'd2
    } enc_state_e;

    localparam logic [1:0] FC_NONE    = 2'b00;
    localparam logic [1:0] FC_GLITCH  = 2'b01;
    localparam logic [1:0] FC_TIMEOUT = 2'b10;

endpackage

// File: rtl/encoder_delta_calc.sv
// Modulo-2^POS_W signed difference between two single-turn samples, plus
// a plausibility check |delta| <= MAX_STEP.
//   cur_i      : new single-turn sample
//   prev_i     : last accepted sample
//   delta_c    : (cur_i - prev_i) mod 2^POS_W, read as signed POS_W-bit
//   in_range_c : high when |delta_c| <= MAX_STEP
module encoder_delta_calc
    import encoder_pkg::*;
#(
    parameter int unsigned POS_W    = ENC_POS_W,
    parameter int unsigned MAX_STEP = 4096
) (
    input  logic [POS_W-1:0] cur_i,
    input  logic [POS_W-1:0] prev_i,
    output logic [POS_W-1:0] delta_c,
    output logic             in_range_c
);

    logic [POS_W:0] mag;

    // One extra bit so the magnitude of -2^(POS_W-1) is representable.
    always_comb begin
        delta_c    = cur_i - prev_i;
        mag        = delta_c[POS_W-1] ? ((POS_W+1)'(0) - {1'b1, delta_c})
                                      : {1'b0, delta_c};
        in_range_c = (mag <= (POS_W+1)'(MAX_STEP));
    end

endmodule

// File: rtl/encoder_pos_tracker.sv
// Unwraps the encoder single-turn angle into a signed multi-turn position,
// reports per-frame velocity and supervises the stream for glitches and
// stalls.
//   sck, rst_n   : clock shared with the reader, async active-low reset
//   encoder_val  : single-turn sample, qualified by data_valid
//   clear_fault  : leave FAULT / resync to INIT
//   position     : signed multi-turn position (POS_W+TURN_W bits)
//   velocity     : signed delta of the last accepted frame (POS_W+1 bits)
//   pos_valid    : one-cycle strobe when position/velocity update
//   fault        : high while in FAULT
//   fault_code   : 00 none, 01 glitch, 10 timeout
// Optional macro VELOCITY_AVG_EN: velocity becomes the 4-frame moving
// average of accepted deltas.
module encoder_pos_tracker
    import encoder_pkg::*;
#(
    parameter int unsigned POS_W        = ENC_POS_W,
    parameter int unsigned TURN_W       = 13,
    parameter int unsigned MAX_STEP     = 4096,
    parameter int unsigned GLITCH_LIMIT = 3,
    parameter int unsigned TIMEOUT      = 1024
) (
    input  logic                    sck,
    input  logic                    rst_n,
    input  logic [POS_W-1:0]        encoder_val,
    input  logic                    data_valid,
    input  logic                    clear_fault,
    output logic [POS_W+TURN_W-1:0] position,
    output logic [POS_W:0]          velocity,
    output logic                    pos_valid,
    output logic                    fault,
    output logic [1:0]              fault_code
);

    localparam int unsigned POS_TOT_W = POS_W + TURN_W;
    localparam int unsigned CNT_W     = $clog2(TIMEOUT + 1);
    localparam int unsigned GC_W      = $clog2(GLITCH_LIMIT + 1);

    enc_state_e             state_q, state_d;
    logic [POS_W-1:0]       prev_q, prev_d;
    logic [POS_TOT_W-1:0]   pos_q, pos_d;
    logic [POS_W:0]         vel_q, vel_d;
    logic                   pv_q, pv_d;
    logic                   fault_q, fault_d;
    logic [1:0]             fc_q, fc_d;
    logic [GC_W-1:0]        glitch_q, glitch_d;
    logic [CNT_W-1:0]       tmo_q, tmo_d;

    logic [POS_W-1:0]       delta_c;
    logic                   in_range_c;

`ifdef VELOCITY_AVG_EN
    // Three previous accepted deltas; the current one completes the window.
    logic [2:0][POS_W-1:0]  hist_q, hist_d;
    logic signed [POS_W+1:0] sum_c;
`endif

    encoder_delta_calc #(
        .POS_W    (POS_W),
        .MAX_STEP (MAX_STEP)
    ) u_delta (
        .cur_i      (encoder_val),
        .prev_i     (prev_q),
        .delta_c    (delta_c),
        .in_range_c (in_range_c)
    );

    // Next-state and output logic. Priority: clear_fault > data_valid > timeout.
    always_comb begin
        state_d  = state_q;
        prev_d   = prev_q;
        pos_d    = pos_q;
        vel_d    = vel_q;
        pv_d     = 1'b0;
        fault_d  = fault_q;
        fc_d     = fc_q;
        glitch_d = glitch_q;
        tmo_d    = tmo_q;
`ifdef VELOCITY_AVG_EN
        hist_d   = hist_q;
        sum_c    = $signed({{2{delta_c[POS_W-1]}}, delta_c})
                 + $signed({{2{hist_q[0][POS_W-1]}}, hist_q[0]})
                 + $signed({{2{hist_q[1][POS_W-1]}}, hist_q[1]})
                 + $signed({{2{hist_q[2][POS_W-1]}}, hist_q[2]});
`endif
        unique case (state_q)
            INIT: begin
                glitch_d = '0;
                tmo_d    = '0;
`ifdef VELOCITY_AVG_EN
                hist_d   = '0;
`endif
                if (!clear_fault && data_valid) begin
                    prev_d  = encoder_val;
                    pos_d   = POS_TOT_W'(encoder_val);
                    vel_d   = '0;
                    pv_d    = 1'b1;
                    state_d = TRACK;
                end
            end
            TRACK: begin
                if (clear_fault) begin
                    state_d  = INIT;
                    glitch_d = '0;
                    tmo_d    = '0;
                end else if (data_valid) begin
                    tmo_d = '0;
                    if (in_range_c) begin
                        prev_d   = encoder_val;
                        pos_d    = pos_q + {{TURN_W{delta_c[POS_W-1]}}, delta_c};
`ifdef VELOCITY_AVG_EN
                        vel_d    = (POS_W+1)'(sum_c >>> 2);
                        hist_d   = {hist_q[1], hist_q[0], delta_c};
`else
                        vel_d    = {delta_c[POS_W-1], delta_c};
`endif
                        pv_d     = 1'b1;
                        glitch_d = '0;
                    end else begin
                        glitch_d = glitch_q + GC_W'(1);
                        if (glitch_d == GC_W'(GLITCH_LIMIT)) begin
                            state_d = FAULT;
                            fault_d = 1'b1;
                            fc_d    = FC_GLITCH;
                        end
                    end
                end else if (tmo_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = FAULT;
                    fault_d = 1'b1;
                    fc_d    = FC_TIMEOUT;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + CNT_W'(1);
                end
            end
            FAULT: begin
                if (clear_fault) begin
                    state_d  = INIT;
                    fault_d  = 1'b0;
                    fc_d     = FC_NONE;
                    glitch_d = '0;
                    tmo_d    = '0;
                end
            end
            default: state_d = INIT;
        endcase
    end

    // State and output registers.
    always_ff @(posedge sck or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= INIT;
            prev_q   <= '0;
            pos_q    <= '0;
            vel_q    <= '0;
            pv_q     <= 1'b0;
            fault_q  <= 1'b0;
            fc_q     <= FC_NONE;
            glitch_q <= '0;
            tmo_q    <= '0;
`ifdef VELOCITY_AVG_EN
            hist_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            prev_q   <= prev_d;
            pos_q    <= pos_d;
            vel_q    <= vel_d;
            pv_q     <= pv_d;
            fault_q  <= fault_d;
            fc_q     <= fc_d;
            glitch_q <= glitch_d;
            tmo_q    <= tmo_d;
`ifdef VELOCITY_AVG_EN
            hist_q   <= hist_d;
`endif
        end
    end

    assign position   = pos_q;
    assign velocity   = vel_q;
    assign pos_valid  = pv_q;
    assign fault      = fault_q;
    assign fault_code = fc_q;

endmodule

// File: tb/tb_encoder_pos_tracker.sv
// Directed bench for encoder_pos_tracker (TIMEOUT shortened to 16).
module tb_encoder_pos_tracker;

`ifdef VELOCITY_AVG_EN
    localparam bit AVG = 1'b1;
`else
    localparam bit AVG = 1'b0;
`endif

    logic        sck = 1'b0;
    logic        rst_n;
    logic [18:0] encoder_val;
    logic        data_valid;
    logic        clear_fault;
    logic [31:0] position;
    logic [19:0] velocity;
    logic        pos_valid;
    logic        fault;
    logic [1:0]  fault_code;

    int total = 0;
    int bad   = 0;

    always #5 sck = ~sck;

    encoder_pos_tracker #(
        .TIMEOUT (16)
    ) dut (
        .sck         (sck),
        .rst_n       (rst_n),
        .encoder_val (encoder_val),
        .data_valid  (data_valid),
        .clear_fault (clear_fault),
        .position    (position),
        .velocity    (velocity),
        .pos_valid   (pos_valid),
        .fault       (fault),
        .fault_code  (fault_code)
    );

    task automatic tick();
        @(posedge sck);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp)
        else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_vel(input string tag, input logic [19:0] raw, input logic [19:0] avg);
        chk(tag, 64'(velocity), 64'(AVG ? avg : raw));
    endtask

    task automatic send(input logic [18:0] v);
        encoder_val = v;
        data_valid  = 1'b1;
        tick();
        data_valid  = 1'b0;
    endtask

    task automatic clr();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
    endtask

    initial begin
        rst_n = 1'b0; encoder_val = '0; data_valid = 1'b0; clear_fault = 1'b0;
        tick(); tick();
        chk("rst_pos",   64'(position),   64'h0);
        chk("rst_vel",   64'(velocity),   64'h0);
        chk("rst_pv",    64'(pos_valid),  64'h0);
        chk("rst_fault", 64'(fault),      64'h0);
        chk("rst_fc",    64'(fault_code), 64'h0);
        rst_n = 1'b1;
        tick();

        // First sample initialises position
        send(19'h00100);
        chk("init_pv",  64'(pos_valid), 64'h1);
        chk("init_pos", 64'(position),  64'h100);
        chk_vel("init_vel", 20'h0, 20'h0);
        tick();
        chk("init_pv_pulse", 64'(pos_valid), 64'h0);

        // Resync, then forward/backward wrap across 0x7FFFF/0x00000
        clr();
        chk("resync_pv",  64'(pos_valid), 64'h0);
        chk("resync_pos", 64'(position),  64'h100);
        send(19'h7FFFE);
        chk("wrap0_pos", 64'(position), 64'h7FFFE);
        send(19'h00001);
        chk("wrapf_pos", 64'(position), 64'h80001);
        chk_vel("wrapf_vel", 20'h3, 20'h0);
        send(19'h7FFFF);
        chk("wrapb_pos", 64'(position), 64'h7FFFF);
        chk_vel("wrapb_vel", 20'hFFFFE, 20'h0);

        // MAX_STEP boundary: -4095, +4096 accepted, +4097 rejected
        send(19'h7F000);
        chk("m4095_pos", 64'(position), 64'h7F000);
        chk_vel("m4095_vel", 20'hFF001, 20'hFFC00);
        send(19'h00000);
        chk("p4096_pos", 64'(position), 64'h80000);
        chk_vel("p4096_vel", 20'h01000, 20'h0);
        send(19'h01001);
        chk("p4097_pv",  64'(pos_valid), 64'h0);
        chk("p4097_pos", 64'(position),  64'h80000);
        send(19'h01000);
        chk("p4096b_pv",  64'(pos_valid), 64'h1);
        chk("p4096b_pos", 64'(position),  64'h81000);
        chk_vel("p4096b_vel", 20'h01000, 20'h003FF);

        // Glitch fault after three rejected frames
        send(19'h20000);
        chk("gl1_pv",    64'(pos_valid), 64'h0);
        chk("gl1_fault", 64'(fault),     64'h0);
        send(19'h20000);
        chk("gl2_fault", 64'(fault),     64'h0);
        send(19'h20000);
        chk("gl3_fault", 64'(fault),      64'h1);
        chk("gl3_fc",    64'(fault_code), 64'h1);
        chk("gl3_pos",   64'(position),   64'h81000);
        send(19'h01001);
        chk("fault_ign_pv",  64'(pos_valid), 64'h0);
        chk("fault_ign_pos", 64'(position),  64'h81000);
        clr();
        chk("clr_fault", 64'(fault),      64'h0);
        chk("clr_fc",    64'(fault_code), 64'h0);
        chk("clr_pos",   64'(position),   64'h81000);
        send(19'h00200);
        chk("reinit_pv",  64'(pos_valid), 64'h1);
        chk("reinit_pos", 64'(position),  64'h200);

        // Timeout: fault exactly 16 cycles after last data_valid
        for (int i = 0; i < 15; i++) tick();
        chk("tmo15_fault", 64'(fault), 64'h0);
        tick();
        chk("tmo16_fault", 64'(fault),      64'h1);
        chk("tmo16_fc",    64'(fault_code), 64'h2);
        clr();
        send(19'h00300);
        for (int i = 0; i < 15; i++) tick();
        send(19'h00301);
        chk("tmo_win_pv",    64'(pos_valid), 64'h1);
        chk("tmo_win_fault", 64'(fault),     64'h0);
        chk("tmo_win_pos",   64'(position),  64'h301);
        chk_vel("tmo_win_vel", 20'h1, 20'h0);
        for (int i = 0; i < 15; i++) tick();
        chk("tmo_rst_fault", 64'(fault), 64'h0);

        // clear_fault together with data_valid: clear wins
        encoder_val = 19'h00305; data_valid = 1'b1; clear_fault = 1'b1;
        tick();
        data_valid = 1'b0; clear_fault = 1'b0;
        chk("clrdv_pv",  64'(pos_valid), 64'h0);
        chk("clrdv_pos", 64'(position),  64'h301);
        for (int i = 0; i < 20; i++) tick();
        chk("init_no_tmo", 64'(fault), 64'h0);
        send(19'h10400);
        chk("clrdv_init_pv",  64'(pos_valid), 64'h1);
        chk("clrdv_init_pos", 64'(position),  64'h10400);

        // Asynchronous reset mid-stream
        send(19'h10401);
        chk("pre_rst_pv", 64'(pos_valid), 64'h1);
        encoder_val = 19'h10402; data_valid = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_pos",   64'(position),  64'h0);
        chk("arst_vel",   64'(velocity),  64'h0);
        chk("arst_pv",    64'(pos_valid), 64'h0);
        chk("arst_fault", 64'(fault),     64'h0);
        tick();
        data_valid = 1'b0;
        rst_n = 1'b1;
        tick();
        chk("post_rst_pv", 64'(pos_valid), 64'h0);

        // Velocity sequence +4, +8, +12, +16 from INIT
        send(19'h00010);
        chk("seq_init_pos", 64'(position), 64'h10);
        send(19'h00014);
        chk_vel("seq_v1", 20'd4, 20'd1);
        send(19'h0001C);
        chk_vel("seq_v2", 20'd8, 20'd3);
        send(19'h00028);
        chk_vel("seq_v3", 20'd12, 20'd6);
        send(19'h00038);
        chk_vel("seq_v4", 20'd16, 20'd10);
        chk("seq_pos", 64'(position), 64'h38);

        // Position below zero wraps as two's complement
        send(19'h7FFF8);
        chk("neg_pos", 64'(position), 64'hFFFFFFF8);
        chk_vel("neg_vel", 20'hFFFC0, 20'hFFFF9);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
